// File: rtl/signed_iterative_divider.sv
// Radix-2 restoring signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder, 2W+1 edge latency.
// Define SIGNED_DIVIDER_SATURATE_EN to clamp out-of-range quotients and raise o_overflow; otherwise they wrap.
module signed_iterative_divider #(
    parameter int INPUT_WIDTH = 18
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_valid,
    input  logic signed [2*INPUT_WIDTH-1:0] i_dividend,
    input  logic signed [INPUT_WIDTH-1:0]   i_divisor,
    output logic                            o_ready,
    output logic signed [INPUT_WIDTH-1:0]   o_quotient,
    output logic signed [INPUT_WIDTH-1:0]   o_remainder,
    output logic                            o_valid,
    output logic                            o_div_by_zero,
    output logic                            o_overflow
);
    localparam int W  = INPUT_WIDTH;
    localparam int DW = 2 * W;
    localparam int CW = $clog2(DW);

    localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic          q_sign;
    logic          dvd_sign;
    logic          dbz;
    logic [DW-1:0] dvd_mag;   // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [W-1:0]  dvs_mag;
    logic [W-1:0]  rem;
    logic [CW-1:0] count;
    logic          accept;
    logic [W:0]    shifted;
    logic          fits;
    logic [W-1:0]  q_res;
    logic [W-1:0]  r_res;
    logic          ovf_res;

    assign o_ready = (state == IDLE);
    assign accept  = o_ready && i_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = CALC;
            CALC:    if (count == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign shifted = {rem, dvd_mag[DW-1]};
    assign fits    = (shifted >= {1'b0, dvs_mag});

    // NOTE: the datapath registers carry no reset; every operation reloads them on its accepting edge.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            q_sign   <= i_dividend[DW-1] ^ i_divisor[W-1];
            dvd_sign <= i_dividend[DW-1];
            dvd_mag  <= i_dividend[DW-1] ? DW'(-i_dividend) : DW'(i_dividend);
            dvs_mag  <= i_divisor[W-1] ? W'(-i_divisor) : W'(i_divisor);
            dbz      <= (i_divisor == '0);
            rem      <= '0;
            count    <= CW'(DW - 1);
        end else if (state == CALC) begin
            rem     <= fits ? W'(shifted - {1'b0, dvs_mag}) : shifted[W-1:0];
            dvd_mag <= {dvd_mag[DW-2:0], fits};
            count   <= count - 1'b1;
        end
    end

    // Remainder magnitude is below |divisor| <= 2^(W-1), so it always fits the signed W-bit result.
    always_comb begin
        q_res   = q_sign ? -dvd_mag[W-1:0] : dvd_mag[W-1:0];
        r_res   = dvd_sign ? -rem : rem;
        ovf_res = 1'b0;
`ifdef SIGNED_DIVIDER_SATURATE_EN
        if (q_sign ? (dvd_mag > {{(DW-W){1'b0}}, Q_MIN})
                   : (dvd_mag > {{(DW-W){1'b0}}, Q_MAX})) begin
            q_res   = q_sign ? Q_MIN : Q_MAX;
            ovf_res = 1'b1;
        end
`endif
        if (dbz) begin
            q_res   = dvd_sign ? Q_MIN : Q_MAX;
            r_res   = '0;
            ovf_res = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_valid       <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_valid <= (state == DONE);
            if (state == DONE) begin
                o_quotient    <= q_res;
                o_remainder   <= r_res;
                o_div_by_zero <= dbz;
                o_overflow    <= ovf_res;
            end
        end
    end

endmodule

// File: tb/tb_signed_iterative_divider.sv
// Self-checking bench for signed_iterative_divider (W=18): directed scenarios plus randomized operands
// checked against an integer-arithmetic reference model.
module tb_signed_iterative_divider;
    localparam int W       = 18;
    localparam int DW      = 2 * W;
    localparam int LATENCY = 2 * W + 1;
    localparam int TIMEOUT = 100;

    localparam logic signed [W-1:0] Q_MAX = 18'h1FFFF;
    localparam logic signed [W-1:0] Q_MIN = 18'h20000;

    typedef struct {
        logic signed [DW-1:0] a;
        logic signed [W-1:0]  b;
        logic signed [W-1:0]  q;
        logic signed [W-1:0]  r;
        logic                 dbz;
        logic                 ovf;
    } vec_t;

    logic                 i_clk;
    logic                 i_reset;
    logic                 i_valid;
    logic signed [DW-1:0] i_dividend;
    logic signed [W-1:0]  i_divisor;
    logic                 o_ready;
    logic signed [W-1:0]  o_quotient;
    logic signed [W-1:0]  o_remainder;
    logic                 o_valid;
    logic                 o_div_by_zero;
    logic                 o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    signed_iterative_divider #(.INPUT_WIDTH(W)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_ready       (o_ready),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_valid       (o_valid),
        .o_div_by_zero (o_div_by_zero),
        .o_overflow    (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain integer division, C-style truncation, remainder sign follows the dividend.
    function automatic void model(input logic signed [DW-1:0] a, input logic signed [W-1:0] b,
                                  output logic signed [W-1:0] q, output logic signed [W-1:0] r,
                                  output logic dbz, output logic ovf);
        longint la, lb, lq, lr;
        la  = longint'(a);
        lb  = longint'(b);
        dbz = 1'b0;
        ovf = 1'b0;
        if (lb == 0) begin
            dbz = 1'b1;
            q   = (la >= 0) ? Q_MAX : Q_MIN;
            r   = '0;
        end else begin
            lq = la / lb;
            lr = la % lb;
            r  = W'(lr);
            q  = W'(lq);
            if (lq > 131071 || lq < -131072) begin
`ifdef SIGNED_DIVIDER_SATURATE_EN
                ovf = 1'b1;
                q   = (lq > 0) ? Q_MAX : Q_MIN;
`endif
            end
        end
    endfunction

    // Presents one operation at the current cycle and waits for its o_valid pulse.
    task automatic run_op(input logic signed [DW-1:0] a, input logic signed [W-1:0] b,
                          output logic signed [W-1:0] q, output logic signed [W-1:0] r,
                          output logic dbz, output logic ovf, output int edges, output logic ready_ok);
        i_valid    = 1'b1;
        i_dividend = a;
        i_divisor  = b;
        @(posedge i_clk); #1;
        i_valid    = 1'b0;
        i_dividend = DW'({$urandom(), $urandom()});
        i_divisor  = W'($urandom());
        edges    = -1;
        ready_ok = 1'b1;
        q = 'x; r = 'x; dbz = 1'bx; ovf = 1'bx;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                edges = k;
                q = o_quotient; r = o_remainder; dbz = o_div_by_zero; ovf = o_overflow;
                if (o_ready !== 1'b1) ready_ok = 1'b0;
                break;
            end
            if (o_ready !== 1'b0) ready_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        i_reset    = 1'b1;
        i_valid    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        n_checks++;
        if ({o_quotient, o_remainder, o_valid, o_div_by_zero, o_overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%0d r=%0d valid=%0b dbz=%0b ovf=%0b, required all 0",
                     o_quotient, o_remainder, o_valid, o_div_by_zero, o_overflow);
        end
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b, required 1", o_ready);
        end
    endtask

    task automatic test_basic;
        logic signed [W-1:0] q, r;
        logic dbz, ovf, ready_ok;
        int edges;
        run_op(36'sd100, 18'sd7, q, r, dbz, ovf, edges, ready_ok);
        n_checks++;
        if (edges !== LATENCY) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges, required %0d", edges, LATENCY);
        end
        n_checks++;
        if (ready_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: o_ready not low throughout or not high with result");
        end
        n_checks++;
        if ({q, r, dbz, ovf} !== {18'sd14, 18'sd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%0b ovf=%0b, required q=14 r=2 dbz=0 ovf=0",
                     q, r, dbz, ovf);
        end
        @(posedge i_clk); #1;
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: o_valid got %0b one cycle later, required 0", o_valid);
        end
        n_checks++;
        if ({o_quotient, o_remainder} !== {18'sd14, 18'sd2}) begin
            n_fail++;
            $display("FAIL basic_hold: got q=%0d r=%0d, required q=14 r=2", o_quotient, o_remainder);
        end
    endtask

    task automatic test_directed;
        vec_t vecs[$];
        logic signed [W-1:0] q, r;
        logic dbz, ovf, ready_ok;
        int edges;
        vecs.push_back('{a: -36'sd100, b: 18'sd7,  q: -18'sd14, r: -18'sd2, dbz: 1'b0, ovf: 1'b0});
        vecs.push_back('{a: 36'sd100,  b: -18'sd7, q: -18'sd14, r: 18'sd2,  dbz: 1'b0, ovf: 1'b0});
        vecs.push_back('{a: -36'sd100, b: -18'sd7, q: 18'sd14,  r: -18'sd2, dbz: 1'b0, ovf: 1'b0});
        vecs.push_back('{a: 36'sd5,    b: 18'sd0,  q: Q_MAX,    r: 18'sd0,  dbz: 1'b1, ovf: 1'b0});
        vecs.push_back('{a: -36'sd5,   b: 18'sd0,  q: Q_MIN,    r: 18'sd0,  dbz: 1'b1, ovf: 1'b0});
        vecs.push_back('{a: -36'sd131072, b: 18'sd1, q: Q_MIN,  r: 18'sd0,  dbz: 1'b0, ovf: 1'b0});
`ifdef SIGNED_DIVIDER_SATURATE_EN
        vecs.push_back('{a: 36'sd131072, b: 18'sd1, q: Q_MAX,   r: 18'sd0,  dbz: 1'b0, ovf: 1'b1});
        vecs.push_back('{a: 36'h800000000, b: 18'sd1, q: Q_MIN, r: 18'sd0,  dbz: 1'b0, ovf: 1'b1});
`else
        vecs.push_back('{a: 36'sd131072, b: 18'sd1, q: Q_MIN,   r: 18'sd0,  dbz: 1'b0, ovf: 1'b0});
        vecs.push_back('{a: 36'h800000000, b: 18'sd1, q: 18'sd0, r: 18'sd0, dbz: 1'b0, ovf: 1'b0});
`endif
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, q, r, dbz, ovf, edges, ready_ok);
            n_checks++;
            if ({q, r, dbz, ovf} !== {vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf} || edges !== LATENCY) begin
                n_fail++;
                $display("FAIL directed_%0d (%0d/%0d): got q=%0d r=%0d dbz=%0b ovf=%0b edges=%0d, required q=%0d r=%0d dbz=%0b ovf=%0b edges=%0d",
                         i, vecs[i].a, vecs[i].b, q, r, dbz, ovf, edges,
                         vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, LATENCY);
            end
        end
    endtask

    task automatic test_ignored_valid;
        int pulses = 0;
        int first_edge = -1;
        logic signed [W-1:0] q = '0;
        logic signed [W-1:0] r = '0;
        i_valid = 1'b1; i_dividend = 36'sd100; i_divisor = 18'sd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_valid = 1'b1; i_dividend = 36'sd9; i_divisor = 18'sd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (int k = 6; k <= 2 * LATENCY + 6; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                pulses++;
                if (first_edge < 0) begin
                    first_edge = k; q = o_quotient; r = o_remainder;
                end
            end
        end
        n_checks++;
        if (pulses !== 1 || first_edge !== LATENCY) begin
            n_fail++;
            $display("FAIL ignored_valid_pulses: got %0d pulses (first at edge %0d), required 1 at edge %0d",
                     pulses, first_edge, LATENCY);
        end
        n_checks++;
        if ({q, r} !== {18'sd14, 18'sd2}) begin
            n_fail++;
            $display("FAIL ignored_valid_result: got q=%0d r=%0d, required q=14 r=2", q, r);
        end
    endtask

    task automatic test_back_to_back;
        logic signed [W-1:0] q, r;
        logic dbz, ovf, ready_ok;
        int edges;
        run_op(36'sd50, 18'sd4, q, r, dbz, ovf, edges, ready_ok);
        // Still inside the o_valid cycle here, so the next operation is offered there.
        run_op(36'sd9, 18'sd3, q, r, dbz, ovf, edges, ready_ok);
        n_checks++;
        if ({q, r, dbz, ovf} !== {18'sd3, 18'sd0, 1'b0, 1'b0} || edges !== LATENCY) begin
            n_fail++;
            $display("FAIL back_to_back: got q=%0d r=%0d dbz=%0b ovf=%0b edges=%0d, required q=3 r=0 dbz=0 ovf=0 edges=%0d",
                     q, r, dbz, ovf, edges, LATENCY);
        end
    endtask

    task automatic test_reset_mid_op;
        logic signed [W-1:0] q, r;
        logic dbz, ovf, ready_ok;
        int edges;
        int pulses = 0;
        i_valid = 1'b1; i_dividend = 36'sd100; i_divisor = 18'sd7;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        n_checks++;
        if ({o_quotient, o_remainder, o_valid, o_div_by_zero, o_overflow} !== '0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_op_state: got q=%0d r=%0d valid=%0b dbz=%0b ovf=%0b ready=%0b, required zeros and ready=1",
                     o_quotient, o_remainder, o_valid, o_div_by_zero, o_overflow, o_ready);
        end
        for (int k = 0; k < LATENCY + 5; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_op_no_valid: got %0d pulses, required 0", pulses);
        end
        run_op(36'sd20, 18'sd6, q, r, dbz, ovf, edges, ready_ok);
        n_checks++;
        if ({q, r} !== {18'sd3, 18'sd2} || edges !== LATENCY) begin
            n_fail++;
            $display("FAIL reset_mid_op_next: got q=%0d r=%0d edges=%0d, required q=3 r=2 edges=%0d",
                     q, r, edges, LATENCY);
        end
    endtask

    task automatic test_random;
        logic signed [DW-1:0] a;
        logic signed [W-1:0]  b;
        logic signed [W-1:0]  q, r, eq, er;
        logic dbz, ovf, edbz, eovf, ready_ok;
        int edges;
        for (int n = 0; n < 40; n++) begin
            a = DW'({$urandom(), $urandom()});
            b = W'($urandom());
            case ($urandom_range(0, 3))
                1: a = {{(DW-21){a[20]}}, a[20:0]};
                2: b = '0;
                3: b = ($urandom_range(0, 1) != 0) ? 18'sd1 : -18'sd1;
                default: ;
            endcase
            model(a, b, eq, er, edbz, eovf);
            run_op(a, b, q, r, dbz, ovf, edges, ready_ok);
            n_checks++;
            if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf}) begin
                n_fail++;
                $display("FAIL random_%0d (%0d/%0d): got q=%0d r=%0d dbz=%0b ovf=%0b, required q=%0d r=%0d dbz=%0b ovf=%0b",
                         n, a, b, q, r, dbz, ovf, eq, er, edbz, eovf);
            end
            n_checks++;
            if (edges !== LATENCY || ready_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL random_timing_%0d: got edges=%0d ready_ok=%0b, required edges=%0d ready_ok=1",
                         n, edges, ready_ok, LATENCY);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_ignored_valid();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
